// File: rtl/v_upd_sched_pkg.sv
// Shared types for the update scheduler: command field types, default requester count,
// and the packed command record used for queue storage and the issue registers.
package v_upd_sched_pkg;

  typedef logic [7:0]  id_t;
  typedef logic [1:0]  cmd_t;
  typedef logic [15:0] key_t;
  typedef logic [7:0]  size_t;

  localparam int unsigned UPD_REQ_N = 4;

  typedef struct packed {
    id_t   prod_id;
    cmd_t  cmd;
    key_t  key;
    size_t size;
  } upd_cmd_t;

endpackage

// File: rtl/v_upd_sched_rr.sv
// Round-robin arbiter with its own priority pointer.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (pointer -> 0)
//   i_req       per-requester request mask
//   i_adv       allow the pointer to move past the winner this cycle
//   o_gnt       one-hot grant, search starts at the pointer
module v_upd_sched_rr #(
  parameter int unsigned REQ_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_N-1:0] i_req,
  input  logic             i_adv,
  output logic [REQ_N-1:0] o_gnt
);

  localparam int unsigned PtrW = (REQ_N > 1) ? $clog2(REQ_N) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d, gnt_idx;
  logic            found;

  always_comb begin
    int unsigned idx;
    idx     = 0;
    o_gnt   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned off = 0; off < REQ_N; off++) begin
      idx = (32'(ptr_q) + off) % REQ_N;
      if (!found && i_req[idx[PtrW-1:0]]) begin
        found                   = 1'b1;
        gnt_idx                 = idx[PtrW-1:0];
        o_gnt[idx[PtrW-1:0]]    = 1'b1;
      end
    end
  end

  // Only an actual winner moves priority; masked requesters keep their place.
  always_comb begin
    ptr_d = ptr_q;
    if (i_adv && found) begin
      if (gnt_idx == PtrW'(REQ_N - 1)) ptr_d = '0;
      else                             ptr_d = gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/v_upd_sched.sv
// Update scheduler: per-requester FIFO queues, round-robin selection and a registered
// issue stage feeding the update pipeline (no backpressure). A head whose prod_id matches
// the update issued last cycle is masked, since the pipe cannot take the same id twice in a row.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_en                issue enable (queues still accept when low)
//   i_req_vld/o_req_rdy per-requester handshake; rdy is ~full from the registered count
//   i_req_*             per-requester command payload
//   o_upd_vld_r, o_upd_*_r  registered issue to the pipe; payload holds when vld drops
//   o_idle              all queues empty and nothing presented
//   o_haz_stall_r       a non-empty head was hazard-masked last cycle
module v_upd_sched
  import v_upd_sched_pkg::*;
#(
  parameter int unsigned REQ_N  = UPD_REQ_N,
  parameter int unsigned QDEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic       [REQ_N-1:0]  i_req_vld,
  output logic       [REQ_N-1:0]  o_req_rdy,
  input  id_t        [REQ_N-1:0]  i_req_prod_id,
  input  cmd_t       [REQ_N-1:0]  i_req_cmd,
  input  key_t       [REQ_N-1:0]  i_req_key,
  input  size_t      [REQ_N-1:0]  i_req_size,
  output logic                    o_upd_vld_r,
  output id_t                     o_upd_prod_id_r,
  output cmd_t                    o_upd_cmd_r,
  output key_t                    o_upd_key_r,
  output size_t                   o_upd_size_r,
  output logic                    o_idle,
  output logic                    o_haz_stall_r
);

  localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic     [REQ_N-1:0] nonempty, push, haz, cand, gnt;
  upd_cmd_t [REQ_N-1:0] head;
  upd_cmd_t             upd_q, upd_sel;
  logic                 upd_vld_q, haz_stall_q;

  for (genvar i = 0; i < REQ_N; i++) begin : g_q
    upd_cmd_t      mem_q [QDEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;

    assign o_req_rdy[i] = (cnt_q != (AW+1)'(QDEPTH));
    assign nonempty[i]  = (cnt_q != '0);
    assign push[i]      = i_req_vld[i] & o_req_rdy[i];
    assign head[i]      = mem_q[rd_ptr_q];
    assign haz[i]       = upd_vld_q & (mem_q[rd_ptr_q].prod_id == upd_q.prod_id);

    // Storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
      if (push[i]) begin
        mem_q[wr_ptr_q] <= '{prod_id: i_req_prod_id[i], cmd: i_req_cmd[i],
                             key: i_req_key[i], size: i_req_size[i]};
      end
    end

    // Pointers wrap naturally because QDEPTH is a power of two.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push[i]) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (gnt[i])  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push[i], gnt[i]})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  assign cand = nonempty & ~haz & {REQ_N{i_en}};

  v_upd_sched_rr #(
    .REQ_N(REQ_N)
  ) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (cand),
    .i_adv (i_en),
    .o_gnt (gnt)
  );

  always_comb begin
    upd_sel = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (gnt[i]) upd_sel = head[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_vld_q   <= 1'b0;
      upd_q       <= '0;
      haz_stall_q <= 1'b0;
    end else begin
      upd_vld_q   <= |gnt;
      if (|gnt) upd_q <= upd_sel;
      haz_stall_q <= i_en & (|(nonempty & haz));
    end
  end

  assign o_upd_vld_r     = upd_vld_q;
  assign o_upd_prod_id_r = upd_q.prod_id;
  assign o_upd_cmd_r     = upd_q.cmd;
  assign o_upd_key_r     = upd_q.key;
  assign o_upd_size_r    = upd_q.size;
  assign o_haz_stall_r   = haz_stall_q;
  assign o_idle          = ~(|nonempty) & ~upd_vld_q;

endmodule

// File: tb/tb_v_upd_sched.sv
// Directed bench for v_upd_sched: expected issues are queued when commands are driven and
// popped by a negedge monitor whenever the scheduler presents an update.
module tb_v_upd_sched;
  import v_upd_sched_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic  [3:0]      req_vld;
  logic  [3:0]      req_rdy;
  id_t   [3:0]      req_id;
  cmd_t  [3:0]      req_cmd;
  key_t  [3:0]      req_key;
  size_t [3:0]      req_size;
  logic             upd_vld;
  id_t              upd_id;
  cmd_t             upd_cmd;
  key_t             upd_key;
  size_t            upd_size;
  logic             idle;
  logic             haz_stall;

  int n_chk = 0;
  int n_err = 0;
  upd_cmd_t sb[$];

  always #5 clk = ~clk;

  v_upd_sched #(
    .REQ_N (4),
    .QDEPTH(2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_en           (en),
    .i_req_vld      (req_vld),
    .o_req_rdy      (req_rdy),
    .i_req_prod_id  (req_id),
    .i_req_cmd      (req_cmd),
    .i_req_key      (req_key),
    .i_req_size     (req_size),
    .o_upd_vld_r    (upd_vld),
    .o_upd_prod_id_r(upd_id),
    .o_upd_cmd_r    (upd_cmd),
    .o_upd_key_r    (upd_key),
    .o_upd_size_r   (upd_size),
    .o_idle         (idle),
    .o_haz_stall_r  (haz_stall)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic upd_cmd_t mk(input id_t id);
    upd_cmd_t c;
    c.prod_id = id;
    c.cmd     = id[1:0];
    c.key     = {8'hA5, id};
    c.size    = id + 8'd1;
    return c;
  endfunction

  task automatic set_req(input int r, input id_t id);
    upd_cmd_t c;
    c           = mk(id);
    req_vld[r]  = 1'b1;
    req_id[r]   = c.prod_id;
    req_cmd[r]  = c.cmd;
    req_key[r]  = c.key;
    req_size[r] = c.size;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    en      = 1'b1;
    req_vld = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Every presented update must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (upd_vld === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_issue", 64'(upd_id), 64'hFFFF);
      end else begin
        upd_cmd_t got;
        upd_cmd_t exp;
        exp         = sb.pop_front();
        got.prod_id = upd_id;
        got.cmd     = upd_cmd;
        got.key     = upd_key;
        got.size    = upd_size;
        check_eq("issue_payload", 64'(got), 64'(exp));
      end
    end
  end

  initial begin
    int enq;
    req_id   = '0;
    req_cmd  = '0;
    req_key  = '0;
    req_size = '0;

    // 1: reset state and single-command latency
    do_reset();
    check_eq("t1_rdy_reset", 64'(req_rdy), 64'hF);
    check_eq("t1_idle_reset", 64'(idle), 64'd1);
    check_eq("t1_vld_reset", 64'(upd_vld), 64'd0);
    check_eq("t1_payload_reset", 64'({upd_id, upd_cmd, upd_key, upd_size}), 64'd0);
    check_eq("t1_haz_reset", 64'(haz_stall), 64'd0);
    set_req(0, 8'd5);
    sb.push_back(mk(8'd5));
    step();
    req_vld = '0;
    check_eq("t1_vld_after_enq_edge", 64'(upd_vld), 64'd0);
    check_eq("t1_not_idle", 64'(idle), 64'd0);
    step();
    check_eq("t1_vld_second_edge", 64'(upd_vld), 64'd1);
    check_eq("t1_id", 64'(upd_id), 64'd5);
    step();
    check_eq("t1_vld_drop", 64'(upd_vld), 64'd0);
    check_eq("t1_idle_after", 64'(idle), 64'd1);
    check_eq("t1_payload_hold", 64'(upd_id), 64'd5);

    // 2: four requesters hold vld for 8 edges; 14 commands get accepted and drain
    //    strictly in 1,2,3,4 rotation with no bubbles.
    do_reset();
    for (int r = 0; r < 4; r++) set_req(r, id_t'(r + 1));
    for (int n = 0; n < 14; n++) sb.push_back(mk(id_t'(n % 4 + 1)));
    enq = 0;
    for (int k = 0; k < 8; k++) begin
      enq += $countones(req_vld & req_rdy);
      step();
      if (k >= 1) check_eq("t2_back_to_back", 64'(upd_vld), 64'd1);
    end
    req_vld = '0;
    for (int k = 0; k < 7; k++) begin
      step();
      check_eq("t2_drain", 64'(upd_vld), 64'd1);
    end
    step();
    check_eq("t2_done", 64'(upd_vld), 64'd0);
    check_eq("t2_enq_count", 64'(enq), 64'd14);
    check_eq("t2_sb_empty", 64'(sb.size()), 64'd0);

    // 3: same id twice from one requester forces a one-cycle bubble
    do_reset();
    set_req(0, 8'd7);
    sb.push_back(mk(8'd7));
    sb.push_back(mk(8'd7));
    step();
    step();
    req_vld = '0;
    check_eq("t3_first", 64'(upd_vld), 64'd1);
    step();
    check_eq("t3_bubble", 64'(upd_vld), 64'd0);
    check_eq("t3_haz_stall", 64'(haz_stall), 64'd1);
    step();
    check_eq("t3_second", 64'(upd_vld), 64'd1);
    check_eq("t3_second_id", 64'(upd_id), 64'd7);
    check_eq("t3_haz_clear", 64'(haz_stall), 64'd0);
    step();
    check_eq("t3_idle", 64'(idle), 64'd1);

    // 4: pointer at 0 after req3 issues id 7; req0 head 7 is masked, req1 (9) wins, req0 next
    do_reset();
    set_req(3, 8'd7);
    sb.push_back(mk(8'd7));
    step();
    req_vld = '0;
    set_req(0, 8'd7);
    set_req(1, 8'd9);
    sb.push_back(mk(8'd9));
    sb.push_back(mk(8'd7));
    step();
    req_vld = '0;
    check_eq("t4_first_id", 64'(upd_id), 64'd7);
    step();
    check_eq("t4_skip_vld", 64'(upd_vld), 64'd1);
    check_eq("t4_skip_id", 64'(upd_id), 64'd9);
    check_eq("t4_haz_stall", 64'(haz_stall), 64'd1);
    step();
    check_eq("t4_req0_vld", 64'(upd_vld), 64'd1);
    check_eq("t4_req0_id", 64'(upd_id), 64'd7);
    step();
    check_eq("t4_idle", 64'(idle), 64'd1);

    // 5: fill req2 with issue disabled; third command refused; release drains two
    do_reset();
    en = 1'b0;
    set_req(2, 8'h21);
    sb.push_back(mk(8'h21));
    sb.push_back(mk(8'h22));
    step();
    set_req(2, 8'h22);
    step();
    check_eq("t5_full_rdy", 64'(req_rdy[2]), 64'd0);
    check_eq("t5_other_rdy", 64'(req_rdy), 64'hB);
    set_req(2, 8'h23);
    step();
    check_eq("t5_still_full", 64'(req_rdy[2]), 64'd0);
    check_eq("t5_no_issue_dis", 64'(upd_vld), 64'd0);
    check_eq("t5_not_idle", 64'(idle), 64'd0);
    req_vld = '0;
    en      = 1'b1;
    step();
    check_eq("t5_issue1", 64'(upd_id), 64'h21);
    check_eq("t5_rdy_back", 64'(req_rdy[2]), 64'd1);
    step();
    check_eq("t5_issue2", 64'(upd_id), 64'h22);
    step();
    check_eq("t5_no_third", 64'(upd_vld), 64'd0);
    check_eq("t5_idle", 64'(idle), 64'd1);

    // 6: reset with three non-empty queues discards everything
    do_reset();
    en = 1'b0;
    set_req(0, 8'h31);
    set_req(1, 8'h32);
    set_req(3, 8'h34);
    step();
    req_vld = '0;
    set_req(0, 8'h35);
    step();
    req_vld = '0;
    sb.push_back(mk(8'h31));
    en = 1'b1;
    step();
    check_eq("t6_pre_issue", 64'(upd_id), 64'h31);
    rst_n = 1'b0;
    step();
    check_eq("t6_vld_in_reset", 64'(upd_vld), 64'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("t6_no_stale", 64'(upd_vld), 64'd0);
    end
    check_eq("t6_idle", 64'(idle), 64'd1);
    check_eq("sb_empty_end", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
